// File: rtl/muldiv_unit.sv
// Iterative multiply/divide coprocessor with HI/LO result registers.
// One multiplier/quotient bit per clock on operand magnitudes; signs are applied in the final FIX cycle.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int DW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
      negate = ~v + WIDTH'(1'b1);
   endfunction

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
      if (is_signed && v[WIDTH-1]) begin
         magnitude = negate(v);
      end else begin
         magnitude = v;
      end
   endfunction

   state_t            state_r;
   state_t            next_s;
   logic [CW-1:0]     cnt_r;
   logic [DW-1:0]     acc_r;
   logic [WIDTH-1:0]  opnd_r;
   logic [WIDTH-1:0]  raw_a_r;
   logic              is_div_r;
   logic              neg_res_r;
   logic              neg_rem_r;
   logic              div_zero_r;
   logic              busy_r;
   logic              done_r;
   logic [WIDTH-1:0]  hi_r;
   logic [WIDTH-1:0]  lo_r;

   logic              load_s;
   logic              step_s;
   logic              finish_s;
   logic              idle_s;
   logic              signed_op_s;
   logic [WIDTH:0]    sum_s;
   logic [WIDTH:0]    shifted_s;
   logic              ge_s;
   logic [DW-1:0]     step_acc_s;
   logic [DW-1:0]     prod_s;
   logic [WIDTH-1:0]  res_hi_s;
   logic [WIDTH-1:0]  res_lo_s;

   assign signed_op_s = ~op[0];

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               next_s = RUN;
            end else begin
               next_s = IDLE;
            end
         end
         RUN: begin
            if (cnt_r == LAST_STEP) begin
               next_s = FIX;
            end else begin
               next_s = RUN;
            end
         end
         FIX:     next_s = IDLE;
         default: next_s = IDLE;
      endcase
   end

   // FSM control outputs
   always_comb begin
      load_s   = 1'b0;
      step_s   = 1'b0;
      finish_s = 1'b0;
      idle_s   = 1'b0;
      case (state_r)
         IDLE: begin
            idle_s = 1'b1;
            load_s = start;
         end
         RUN:     step_s   = 1'b1;
         FIX:     finish_s = 1'b1;
         default: idle_s   = 1'b0;
      endcase
   end

   // Iteration counter, cleared whenever the unit is not iterating
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CW{1'b0}};
      end else if (step_s) begin
         cnt_r <= cnt_r + CW'(1'b1);
      end else begin
         cnt_r <= {CW{1'b0}};
      end
   end

   // One iteration step: shift-add for multiply, restoring subtract for divide.
   // The accumulator low half starts as multiplier/dividend and ends as product-low/quotient.
   always_comb begin
      sum_s      = {1'b0, acc_r[DW-1:WIDTH]} + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
      shifted_s  = {acc_r[DW-1:WIDTH], acc_r[WIDTH-1]};
      ge_s       = (shifted_s >= {1'b0, opnd_r});
      step_acc_s = acc_r;
      if (is_div_r) begin
         if (ge_s) begin
            step_acc_s = {shifted_s[WIDTH-1:0] - opnd_r, acc_r[WIDTH-2:0], 1'b1};
         end else begin
            step_acc_s = {shifted_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
         end
      end else begin
         step_acc_s = {sum_s, acc_r[WIDTH-1:1]};
      end
   end

   // Sign correction and special cases applied to the magnitude result
   always_comb begin
      prod_s   = neg_res_r ? (~acc_r + DW'(1'b1)) : acc_r;
      res_hi_s = prod_s[DW-1:WIDTH];
      res_lo_s = prod_s[WIDTH-1:0];
      if (is_div_r) begin
         if (div_zero_r) begin
            res_hi_s = raw_a_r;
            res_lo_s = {WIDTH{1'b1}};
         end else begin
            res_hi_s = neg_rem_r ? negate(acc_r[DW-1:WIDTH]) : acc_r[DW-1:WIDTH];
            res_lo_s = neg_res_r ? negate(acc_r[WIDTH-1:0])  : acc_r[WIDTH-1:0];
         end
      end else begin
         res_hi_s = prod_s[DW-1:WIDTH];
         res_lo_s = prod_s[WIDTH-1:0];
      end
   end

   // Operand capture at start and accumulator iteration
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r      <= {DW{1'b0}};
         opnd_r     <= {WIDTH{1'b0}};
         raw_a_r    <= {WIDTH{1'b0}};
         is_div_r   <= 1'b0;
         neg_res_r  <= 1'b0;
         neg_rem_r  <= 1'b0;
         div_zero_r <= 1'b0;
      end else if (load_s) begin
         acc_r      <= {{WIDTH{1'b0}}, magnitude(operand_a, signed_op_s)};
         opnd_r     <= magnitude(operand_b, signed_op_s);
         raw_a_r    <= operand_a;
         is_div_r   <= op[1];
         neg_res_r  <= signed_op_s & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
         neg_rem_r  <= signed_op_s & operand_a[WIDTH-1];
         div_zero_r <= (operand_b == {WIDTH{1'b0}});
      end else if (step_s) begin
         acc_r <= step_acc_s;
      end else begin
         acc_r <= acc_r;
      end
   end

   // HI/LO: operation results in FIX, MTHI/MTLO only while idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_r <= {WIDTH{1'b0}};
         lo_r <= {WIDTH{1'b0}};
      end else if (finish_s) begin
         hi_r <= res_hi_s;
         lo_r <= res_lo_s;
      end else if (idle_s) begin
         if (hi_we) begin
            hi_r <= wr_data;
         end else begin
            hi_r <= hi_r;
         end
         if (lo_we) begin
            lo_r <= wr_data;
         end else begin
            lo_r <= lo_r;
         end
      end else begin
         hi_r <= hi_r;
         lo_r <= lo_r;
      end
   end

   // Handshake flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         done_r <= finish_s;
         if (load_s) begin
            busy_r <= 1'b1;
         end else if (finish_s) begin
            busy_r <= 1'b0;
         end else begin
            busy_r <= busy_r;
         end
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign hi   = hi_r;
   assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32) with hand-computed expected values.
module tb_muldiv_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wr_data;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op        (op),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .hi_we     (hi_we),
      .lo_we     (lo_we),
      .wr_data   (wr_data),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Starts an operation at the current negedge and waits for done (bounded).
   // With inject set, a start plus MTHI is attempted in the 5th busy cycle.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit inject, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int          n;
      bit          held;
      logic [31:0] hi0;
      logic [31:0] lo0;
      start     = 1'b1;
      op        = o;
      operand_a = a;
      operand_b = b;
      @(negedge clk);
      start     = 1'b0;
      operand_a = 32'h5A5A_A5A5;
      operand_b = 32'h0000_0003;
      hi0  = hi;
      lo0  = lo;
      held = 1'b1;
      n    = 0;
      while (!done && n < 100) begin
         if (busy) n++;
         if (hi !== hi0 || lo !== lo0) held = 1'b0;
         if (inject && n == 5) begin
            start     = 1'b1;
            op        = OP_MULTU;
            operand_a = 32'd2;
            operand_b = 32'd3;
            hi_we     = 1'b1;
            wr_data   = 32'h0000_1234;
         end else begin
            start = 1'b0;
            hi_we = 1'b0;
         end
         @(negedge clk);
      end
      check({tag, "_busy_cycles"}, 64'(n), 64'd33);
      check({tag, "_hold"}, 64'(held), 64'd1);
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
      check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      op        = 2'b00;
      operand_a = 32'd0;
      operand_b = 32'd0;
      hi_we     = 1'b0;
      lo_we     = 1'b0;
      wr_data   = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_hi",   64'(hi),   64'd0);
      check("rst_lo",   64'(lo),   64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
      @(negedge clk);
      check("done_pulse", 64'(done), 64'd0);
      check("busy_after", 64'(busy), 64'd0);
      check("hi_kept",    64'(hi),   64'h0000_0000_FFFF_FFFE);

      run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op("div_b2b",  OP_DIV,  32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      @(negedge clk);

      run_op("divu_zero", OP_DIVU, 32'd7,        32'd0,        1'b0, 32'h0000_0007, 32'hFFFF_FFFF);
      run_op("div_ovf",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h8000_0000);
      @(negedge clk);

      run_op("divu_inject", OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
      @(negedge clk);
      check("inject_no_start", 64'(busy), 64'd0);

      hi_we   = 1'b1;
      lo_we   = 1'b1;
      wr_data = 32'hCAFE_BABE;
      @(negedge clk);
      hi_we = 1'b0;
      lo_we = 1'b0;
      check("mthi",      64'(hi),   64'h0000_0000_CAFE_BABE);
      check("mtlo",      64'(lo),   64'h0000_0000_CAFE_BABE);
      check("mt_nodone", 64'(done), 64'd0);

      run_op("multu_small", OP_MULTU, 32'd5, 32'd6, 1'b0, 32'd0, 32'd30);
      @(negedge clk);

      start     = 1'b1;
      op        = OP_MULTU;
      operand_a = 32'h0000_FFFF;
      operand_b = 32'h0000_FFFF;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_hi",   64'(hi),   64'd0);
      check("arst_lo",   64'(lo),   64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_done", 64'(done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_busy", 64'(busy), 64'd0);

      run_op("divu_after_rst", OP_DIVU, 32'd9, 32'd4, 1'b0, 32'd1, 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
